// File: rtl/cond_logic_pkg.sv
// ============================================================================
// Module : arm_cond_pkg
// Brief  : Condition-code encodings and NZCV/FlagW bit positions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package arm_cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N   = 3;
    localparam int FLAG_Z   = 2;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

`default_nettype wire

// File: rtl/cond_logic_if.sv
// ============================================================================
// Module : cond_logic_if
// Brief  : Decoder/ALU to conditional-execution bundle. COND_PERF_CNT_EN adds
//          the ExecCount/SkipCount signals.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cond_logic_if #(
    parameter int CNT_W = 32
);
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
    );
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags, ExecCount, SkipCount
    );
`else
    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
`endif
endinterface

`default_nettype wire

// File: rtl/cond_logic_check.sv
// ============================================================================
// Module : cond_check
// Brief  : Combinational evaluation of a 4-bit Cond field against NZCV.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cond_check
    import arm_cond_pkg::*;
(
    input  cond_e      cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = flags_i[FLAG_N];
    assign w_z = flags_i[FLAG_Z];
    assign w_c = flags_i[FLAG_C];
    assign w_v = flags_i[FLAG_V];

    always_comb begin
        cond_ex_o = 1'b0;
        unique case (cond_i)
            COND_EQ: cond_ex_o = w_z;
            COND_NE: cond_ex_o = !w_z;
            COND_CS: cond_ex_o = w_c;
            COND_CC: cond_ex_o = !w_c;
            COND_MI: cond_ex_o = w_n;
            COND_PL: cond_ex_o = !w_n;
            COND_VS: cond_ex_o = w_v;
            COND_VC: cond_ex_o = !w_v;
            COND_HI: cond_ex_o = w_c && !w_z;
            COND_LS: cond_ex_o = !w_c || w_z;
            COND_GE: cond_ex_o = (w_n == w_v);
            COND_LT: cond_ex_o = (w_n != w_v);
            COND_GT: cond_ex_o = !w_z && (w_n == w_v);
            COND_LE: cond_ex_o = w_z || (w_n != w_v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b0;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
// Module : cond_logic
// Brief  : NZCV flag register, condition check and write-enable gating.
//          COND_PERF_CNT_EN adds saturating executed/skipped counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cond_logic
    import arm_cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    cond_logic_if.slave  bus
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic [3:0] flags_w;
    logic       cond_ex_w;

    assign flags_w = {nz_q, cv_q};

    cond_check u_cond_check (
        .cond_i    (cond_e'(bus.Cond)),
        .flags_i   (flags_w),
        .cond_ex_o (cond_ex_w)
    );

    // Flags are only written by instructions that actually execute.
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (bus.FlagW[FLAGW_NZ] && cond_ex_w) nz_d = bus.ALUFlags[FLAG_N:FLAG_Z];
        if (bus.FlagW[FLAGW_CV] && cond_ex_w) cv_d = bus.ALUFlags[FLAG_C:FLAG_V];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    assign bus.CondEx   = cond_ex_w;
    assign bus.Flags    = flags_w;
    assign bus.PCSrc    = bus.PCS  && cond_ex_w;
    assign bus.RegWrite = bus.RegW && cond_ex_w && !bus.NoWrite;
    assign bus.MemWrite = bus.MemW && cond_ex_w;

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;

    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (cond_ex_w) begin
            if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
        end else begin
            if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            exec_q <= exec_d;
            skip_q <= skip_d;
        end
    end

    assign bus.ExecCount = exec_q;
    assign bus.SkipCount = skip_q;
`endif

endmodule

`default_nettype wire
